// File: rtl/resp_sig_pkg.sv
// Shared definitions for the response signature collector.
//   WORD_W      : width of one fold word and of the MISR.
//   DEF_POLY    : default MISR feedback polynomial.
//   sig_state_e : collector run states.
//   misr_step   : one shift/feedback/inject step of the MISR.
package resp_sig_pkg;

    localparam int          WORD_W   = 32;
    localparam logic [31:0] DEF_POLY = 32'h04C11DB7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sig_state_e;

    function automatic logic [WORD_W-1:0] misr_step(
        input logic [WORD_W-1:0] sig,
        input logic [WORD_W-1:0] fold,
        input logic [WORD_W-1:0] poly
    );
        return {sig[WORD_W-2:0], 1'b0} ^ (sig[WORD_W-1] ? poly : '0) ^ fold;
    endfunction

endpackage

// File: rtl/resp_sig_collector_if.sv
// Control, sample and status bundle for resp_sig_collector.
//   master : harness side, drives run control and the observed samples.
//   slave  : collector side, returns busy/done/signature/sample_count/match.
interface resp_sig_collector_if #(
    parameter int OUT_W = 330,
    parameter int SIG_W = 32,
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [SIG_W-1:0] seed;
    logic [CNT_W-1:0] skip_n;
    logic [CNT_W-1:0] num_n;
    logic [SIG_W-1:0] exp_sig;
    logic             sample_valid;
    logic [OUT_W-1:0] sample_data;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] signature;
    logic [CNT_W-1:0] sample_count;
    logic             match;

    modport master (
        output start, abort, seed, skip_n, num_n, exp_sig, sample_valid, sample_data,
        input  busy, done, signature, sample_count, match
    );

    modport slave (
        input  start, abort, seed, skip_n, num_n, exp_sig, sample_valid, sample_data,
        output busy, done, signature, sample_count, match
    );
endinterface

// File: rtl/sig_fold.sv
// Combinational pad-and-XOR reducer: zero-pads an OUT_W-bit vector up to a
// whole number of 32-bit words and XORs all words together.
//   data : input vector, OUT_W bits.
//   fold : 32-bit XOR of all padded words.
module sig_fold
    import resp_sig_pkg::*;
#(
    parameter int OUT_W = 330
) (
    input  logic [OUT_W-1:0]  data,
    output logic [WORD_W-1:0] fold
);
    localparam int NW = (OUT_W + WORD_W - 1) / WORD_W;

    logic [NW*WORD_W-1:0] padded;

    always_comb begin
        padded            = '0;
        padded[OUT_W-1:0] = data;
    end

    always_comb begin
        fold = '0;
        for (int i = 0; i < NW; i++) begin
            fold = fold ^ padded[i*WORD_W +: WORD_W];
        end
    end
endmodule

// File: rtl/resp_sig_collector.sv
// Response compactor: folds every accepted sample into a 32-bit MISR
// signature after discarding skip_n leading samples, for num_n samples.
//   clk, rst : clock (rising edge) and asynchronous active-high reset.
//   bus      : slave side of resp_sig_collector_if (run control, samples,
//              busy/done/signature/sample_count/match status).
module resp_sig_collector
    import resp_sig_pkg::*;
#(
    parameter int          OUT_W = 330,
    parameter int          SIG_W = 32,
    parameter int          CNT_W = 16,
    parameter logic [31:0] POLY  = DEF_POLY
) (
    input  logic                clk,
    input  logic                rst,
    resp_sig_collector_if.slave bus
);
    logic [WORD_W-1:0] fold;
    sig_state_e        state;
    logic [SIG_W-1:0]  sig_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  skip_q;
    logic [CNT_W-1:0]  num_q;

    sig_fold #(.OUT_W(OUT_W)) u_fold (
        .data (bus.sample_data),
        .fold (fold)
    );

    // abort beats start, start beats sample_valid; abort keeps the
    // signature and count so a stopped run can still be inspected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sig_q  <= '0;
            cnt_q  <= '0;
            skip_q <= '0;
            num_q  <= '0;
        end else if (bus.abort) begin
            state <= IDLE;
        end else if (bus.start) begin
            sig_q  <= bus.seed;
            cnt_q  <= '0;
            skip_q <= bus.skip_n;
            num_q  <= bus.num_n;
            if (bus.num_n == '0)
                state <= DONE;
            else if (bus.skip_n == '0)
                state <= RUN;
            else
                state <= WARM;
        end else begin
            case (state)
                WARM: begin
                    if (bus.sample_valid) begin
                        skip_q <= skip_q - CNT_W'(1);
                        if (skip_q == CNT_W'(1))
                            state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.sample_valid) begin
                        sig_q <= misr_step(sig_q, fold, POLY);
                        cnt_q <= cnt_q + CNT_W'(1);
                        // cnt_q < num_q here, so the increment cannot wrap.
                        if (cnt_q + CNT_W'(1) == num_q)
                            state <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = (state == WARM) || (state == RUN);
    assign bus.done         = (state == DONE);
    assign bus.signature    = sig_q;
    assign bus.sample_count = cnt_q;
    assign bus.match        = (state == DONE) && (sig_q == bus.exp_sig);
endmodule
